// File: rtl/bram_stream_reader.sv
// Streams LENGTH words from a 1-cycle-latency BRAM port as AXI-Stream; first beat 3 cycles after start.
// Full tready backpressure: a 2-entry skid buffer plus at most one in-flight read, never overrun.
module bram_stream_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   output logic                  busy,
   output logic                  done,
   output logic                  bram_rden,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   input  logic [DATA_WIDTH-1:0] bram_dout,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_next_addr;
   logic [ADDR_WIDTH-1:0] r_last_addr;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_issued;
   logic                  r_inflight;
   logic                  r_inflight_last;
   logic                  r_b0_vld;
   logic                  r_b0_last;
   logic [DATA_WIDTH-1:0] r_b0_dat;
   logic                  r_b1_vld;
   logic                  r_b1_last;
   logic [DATA_WIDTH-1:0] r_b1_dat;

   logic                  w_pop;
   logic                  w_push;
   logic                  w_issue;
   logic                  w_issue_last;
   logic                  w_room;
   logic [1:0]            w_occ;

   assign w_pop        = r_b0_vld & m_axis_tready;
   assign w_push       = r_inflight;
   // Counting this cycle's pop as free space is what sustains one word per clock.
   assign w_occ        = {1'b0, r_b0_vld} + {1'b0, r_b1_vld} + {1'b0, r_inflight} - {1'b0, w_pop};
   assign w_room       = (w_occ < 2'd2);
   assign w_issue_last = (r_issued == (r_len - LEN_WIDTH'(1)));

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = (length == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            w_issue = (r_issued < r_len) && w_room;
            if (w_pop && r_b0_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_next_addr     <= '0;
         r_last_addr     <= '0;
         r_len           <= '0;
         r_issued        <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflight_last <= w_issue_last;
            r_issued        <= r_issued + LEN_WIDTH'(1);
            r_last_addr     <= r_next_addr;
            r_next_addr     <= r_next_addr + ADDR_WIDTH'(1);
         end
         if ((r_state == S_IDLE) && start && (length != '0)) begin
            r_len       <= length;
            r_issued    <= '0;
            r_next_addr <= start_addr;
         end
      end
   end

   // Two-entry shift buffer: entry 0 is always the head so the stream outputs come straight from flops.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_b0_vld  <= 1'b0;
         r_b0_last <= 1'b0;
         r_b0_dat  <= '0;
         r_b1_vld  <= 1'b0;
         r_b1_last <= 1'b0;
         r_b1_dat  <= '0;
      end else if (w_pop) begin
         if (r_b1_vld) begin
            r_b0_vld  <= 1'b1;
            r_b0_last <= r_b1_last;
            r_b0_dat  <= r_b1_dat;
            if (w_push) begin
               r_b1_last <= r_inflight_last;
               r_b1_dat  <= bram_dout;
            end else begin
               r_b1_vld <= 1'b0;
            end
         end else if (w_push) begin
            r_b0_last <= r_inflight_last;
            r_b0_dat  <= bram_dout;
         end else begin
            r_b0_vld <= 1'b0;
         end
      end else if (w_push) begin
         if (!r_b0_vld) begin
            r_b0_vld  <= 1'b1;
            r_b0_last <= r_inflight_last;
            r_b0_dat  <= bram_dout;
         end else begin
            r_b1_vld  <= 1'b1;
            r_b1_last <= r_inflight_last;
            r_b1_dat  <= bram_dout;
         end
      end
   end

   assign busy          = (r_state == S_RUN);
   assign done          = (r_state == S_DONE);
   assign bram_rden     = w_issue;
   assign bram_addr     = w_issue ? r_next_addr : r_last_addr;
   assign m_axis_tdata  = r_b0_dat;
   assign m_axis_tvalid = r_b0_vld;
   assign m_axis_tlast  = r_b0_last;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: BRAM model, queue-based expected beat/address model, directed and random commands.
module tb_bram_stream_reader;
   localparam int DW = 32;
   localparam int AW = 16;
   localparam int LW = 17;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [LW-1:0] length = '0;
   logic          busy;
   logic          done;
   logic          bram_rden;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_dout = '0;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          m_axis_tlast;

   bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rstn(rstn), .start(start), .start_addr(start_addr), .length(length),
      .busy(busy), .done(done), .bram_rden(bram_rden), .bram_addr(bram_addr), .bram_dout(bram_dout),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0] mem [0:65535];
   always @(posedge clk) if (bram_rden) bram_dout <= mem[bram_addr];

   logic [DW:0]   exp_beats[$];
   logic [AW-1:0] exp_addrs[$];
   int checks = 0;
   int errors = 0;
   int hs_cnt, rden_cnt, done_cnt;
   int first_rden_cyc, first_vld_cyc, first_hs_cyc, last_hs_cyc, start_cyc;
   int tr_mode = 0;
   int tr_k = 0;
   logic [15:0] tr_pat = 16'b1001_0100_1101_0101;
   logic        prev_stall = 1'b0;
   logic [DW:0] prev_beat = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rstn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("tvalid_held", 64'(m_axis_tvalid), 64'd1);
            check("beat_held", 64'({m_axis_tlast, m_axis_tdata}), 64'(prev_beat));
         end
         if (m_axis_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
         if (bram_rden) begin
            check("rden_only_busy", 64'(busy), 64'd1);
            check("rden_expected", 64'(exp_addrs.size() != 0), 64'd1);
            if (exp_addrs.size() != 0) check("rden_addr", 64'(bram_addr), 64'(exp_addrs.pop_front()));
            rden_cnt++;
            if (first_rden_cyc < 0) first_rden_cyc = cyc;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            check("beat_expected", 64'(exp_beats.size() != 0), 64'd1);
            if (exp_beats.size() != 0) check("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(exp_beats.pop_front()));
            hs_cnt++;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
            last_hs_cyc = cyc;
         end
         if (bram_rden) check("issue_bound", 64'(rden_cnt <= hs_cnt + 2), 64'd1);
         if (done) done_cnt++;
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_beat  = {m_axis_tlast, m_axis_tdata};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      tr_k++;
      case (tr_mode)
         0: m_axis_tready = 1'b1;
         1: m_axis_tready = tr_pat[15 - (tr_k % 16)];
         2: m_axis_tready = 1'($urandom_range(0, 1));
         default: m_axis_tready = 1'b0;
      endcase
   endtask

   // Drives a one-cycle start; the model only records words for commands the DUT should accept.
   task automatic issue_cmd(input logic [AW-1:0] a, input int len, input bit accept);
      logic [AW-1:0] w;
      if (accept) begin
         for (int i = 0; i < len; i++) begin
            w = a + AW'(i);
            exp_addrs.push_back(w);
            exp_beats.push_back({(i == len - 1), mem[w]});
         end
         hs_cnt = 0; rden_cnt = 0;
         first_rden_cyc = -1; first_vld_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1;
         start_cyc = cyc;
      end
      start = 1'b1; start_addr = a; length = LW'(len);
      tick();
      start = 1'b0;
   endtask

   // Returns in the cycle where done is high.
   task automatic wait_done(input int budget);
      int k = 0;
      while (!done && k < budget) begin
         tick();
         k++;
      end
      check("done_seen", 64'(done), 64'd1);
   endtask

   task automatic finish_cmd(input int budget);
      wait_done(budget);
      tick();
      check("done_one_cycle", 64'(done), 64'd0);
      check("beats_left", 64'(exp_beats.size()), 64'd0);
      check("addrs_left", 64'(exp_addrs.size()), 64'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_rden"}, 64'(bram_rden), 64'd0);
      check({tag, "_addr"}, 64'(bram_addr), 64'd0);
      check({tag, "_tdata"}, 64'(m_axis_tdata), 64'd0);
      check({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
      check({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
   endtask

   initial begin
      int d0, k, len;
      logic [AW-1:0] a;
      for (int i = 0; i < 65536; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[16'h0010 + i] = 32'hA0A0_0000 + i;

      // reset state
      #1;
      check_idle_outputs("reset");
      tick(); tick();
      rstn = 1'b1;
      tick();

      // 1) streaming with tready held high, latency and back-to-back beats
      tr_mode = 0; m_axis_tready = 1'b1;
      issue_cmd(16'h0010, 4, 1'b1);
      wait_done(50);
      check("t1_rden_latency", 64'(first_rden_cyc - start_cyc), 64'd1);
      check("t1_tvalid_latency", 64'(first_vld_cyc - start_cyc), 64'd3);
      check("t1_consecutive", 64'(last_hs_cyc - first_hs_cyc), 64'd3);
      check("t1_done_after_last", 64'(cyc - last_hs_cyc), 64'd1);
      check("t1_beats", 64'(hs_cnt), 64'd4);
      tick();
      check("t1_left", 64'(exp_beats.size()), 64'd0);

      // 2) toggling tready
      tr_mode = 1; tr_k = 0;
      issue_cmd(16'h0010, 4, 1'b1);
      finish_cmd(100);

      // 3) address wrap
      tr_mode = 0;
      issue_cmd(16'hFFFE, 4, 1'b1);
      finish_cmd(50);

      // 4) empty command
      d0 = done_cnt;
      issue_cmd(16'h0020, 0, 1'b1);
      check("t4_busy", 64'(busy), 64'd0);
      check("t4_done", 64'(done), 64'd1);
      check("t4_tvalid", 64'(m_axis_tvalid), 64'd0);
      tick();
      check("t4_done_once", 64'(done_cnt - d0), 64'd1);
      check("t4_busy_after", 64'(busy), 64'd0);

      // 5) start while busy and in the done cycle are ignored
      tr_mode = 1; tr_k = 0;
      issue_cmd(16'h0040, 4, 1'b1);
      tick(); tick();
      check("t5_busy_mid", 64'(busy), 64'd1);
      issue_cmd(16'h0100, 4, 1'b0);
      wait_done(100);
      issue_cmd(16'h0200, 3, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("t5_ignored_busy", 64'(busy), 64'd0);
         tick();
      end
      check("t5_left", 64'(exp_beats.size()), 64'd0);
      tr_mode = 2;
      issue_cmd(16'h0300, 5, 1'b1);
      finish_cmd(200);

      // 6) reset mid-transfer
      tr_mode = 0;
      d0 = done_cnt;
      issue_cmd(16'h0050, 4, 1'b1);
      k = 0;
      while (hs_cnt < 2 && k < 50) begin
         tick();
         k++;
      end
      tr_mode = 3; m_axis_tready = 1'b0;
      check("t6_two_beats", 64'(hs_cnt), 64'd2);
      tick(); tick();
      rstn = 1'b0;
      #1;
      check_idle_outputs("t6_reset");
      exp_beats.delete(); exp_addrs.delete();
      tick(); tick();
      rstn = 1'b1;
      tick(); tick();
      check("t6_no_done", 64'(done_cnt - d0), 64'd0);
      tr_mode = 0; m_axis_tready = 1'b1;
      issue_cmd(16'h0000, 1, 1'b1);
      finish_cmd(50);
      check("t6_single_beat", 64'(hs_cnt), 64'd1);

      // random commands, including a long burst across the top of the address space
      tr_mode = 2;
      for (int n = 0; n < 12; n++) begin
         a = AW'($urandom);
         len = $urandom_range(1, 24);
         issue_cmd(a, len, 1'b1);
         finish_cmd(len * 30 + 50);
         check("rand_beats", 64'(hs_cnt), 64'(len));
      end
      issue_cmd(16'hFF80, 300, 1'b1);
      finish_cmd(9000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
